// File: rtl/bin_to_gray_encoder_if.sv
// rtl/bin_to_gray_encoder_if.sv - valid/ready stream bundle for the binary-to-Gray encoder
interface bin_to_gray_encoder_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gray;
    logic             out_step;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_gray, out_step
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_gray, out_step
    );
endinterface

// File: rtl/bin_to_gray_encoder.sv
// rtl/bin_to_gray_encoder.sv - streaming binary-to-Gray encoder with 2-entry buffer; optional GRAY_STEP_CHECK_EN
module bin_to_gray_encoder #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    bin_to_gray_encoder_if.slave bus
);
    logic [1:0]       count;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] in_gray;
    logic             push;
    logic             pop;

    assign in_gray       = bus.in_bin ^ (bus.in_bin >> 1);
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_gray  = head_q;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // head_q always holds the oldest word; tail_q is only meaningful at count=2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    count <= count + 2'd1;
                    if (count == 2'd0) head_q <= in_gray;
                    else               tail_q <= in_gray;
                end
                2'b01: begin
                    count  <= count - 2'd1;
                    head_q <= tail_q;
                end
                2'b11: begin
                    // only reachable at count=1: the new word replaces the departing head
                    head_q <= in_gray;
                end
                default: ;
            endcase
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] last_gray;
    logic             have_prev;
    logic [WIDTH-1:0] diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gray <= '0;
            have_prev <= 1'b0;
        end else if (pop) begin
            last_gray <= head_q;
            have_prev <= 1'b1;
        end
    end

    // exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero
    assign diff         = head_q ^ last_gray;
    assign bus.out_step = bus.out_valid && have_prev && (diff != '0)
                          && ((diff & (diff - WIDTH'(1))) == '0);
`else
    assign bus.out_step = 1'b0;
`endif
endmodule
